regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline writeback (WB);
  - a multi-cycle unit (MU), e.g. multiply/divide or a load returning late.
- Holds a per-register pending scoreboard for MU destinations and drives the decode-stage hazard (stall) signal.
- Sits between the Writeback stage, the MU and the regFile write inputs (regWrite/WA/WD).
- Enforces a starvation bound on MU by freezing the pipeline for one cycle.

Parameters:
- W, 16, data width of register file entries
- N, 3, register address width (2**N registers)
- STARVE_MAX, 4, consecutive MU wait cycles before a forced freeze slot (1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- wb_valid  in  1  WB has a register write this cycle
- wb_addr  in  N  WB destination register
- wb_data  in  W  WB write data
- mu_issue  in  1  decode issued an MU op this cycle (sets pending)
- mu_issue_addr  in  N  destination of the issued MU op
- mu_valid  in  1  MU result available
- mu_addr  in  N  MU result destination
- mu_data  in  W  MU result data
- mu_ready  out  1  MU result accepted this cycle (valid&ready = transfer)
- rd_src  in  N  decode source register
- rd_dst  in  N  decode destination register
- hazard  out  1  decode must stall (operand or destination pending)
- pipe_freeze  out  1  pipeline must hold all stages this cycle
- regWrite  out  1  regFile write enable
- WA  out  N  regFile write address
- WD  out  W  regFile write data

Behaviour:
- Reset (rst=0 at an edge):
  - regWrite=0, WA=0, WD=0, pending=0, state=NORMAL, wait_cnt=0.
  - mu_ready=0, pipe_freeze=0 and hazard=0 while rst=0.
- States: NORMAL, FREEZE. pipe_freeze = (state==FREEZE).
- NORMAL grant:
  - WB has fixed priority.
  - mu_ready = !wb_valid.
  - grant = WB if wb_valid, else MU if mu_valid, else none.
- FREEZE grant:
  - mu_ready=1 and MU is granted if mu_valid.
  - wb_valid is ignored. The frozen WB instruction is held and presented again next cycle; it is not lost.
- Write-port output register, 1-cycle latency:
  - On the edge after a grant: regWrite=1, WA/WD = the granted addr/data.
  - With no grant: regWrite=0, and WA/WD hold their last values.
- Starvation counter (wait_cnt, 4 bits):
  - NORMAL and mu_valid & !mu_ready: wait_cnt++.
  - Any MU transfer, or mu_valid=0: wait_cnt=0.
  - NORMAL, mu_valid & !mu_ready & wait_cnt==STARVE_MAX-1: next state=FREEZE.
  - FREEZE lasts exactly one cycle, then NORMAL with wait_cnt=0.
  - If mu_valid drops during FREEZE, the slot is unused and the state still returns to NORMAL.
- Scoreboard pending[2**N]:
  - Set: mu_issue sets pending[mu_issue_addr] at the edge.
  - Clear: an MU transfer clears pending[mu_addr] at the edge.
  - Same address set and cleared in one cycle: set wins.
  - WB writes never modify pending.
  - MU issue to an already pending register is illegal. Decode prevents it via hazard; the bench asserts it never occurs.
- hazard (combinational):
  - hazard = pending[rd_src] | pending[rd_dst] | (MU output write in flight this cycle to rd_src or rd_dst).
  - The in-flight term means regWrite=1 from an MU grant and WA equal to rd_src or rd_dst. It covers the one-cycle write latency.
  - hazard is not affected by pipe_freeze.
- Reset mid-operation: pending, counter and state are discarded; an in-flight write is dropped (regWrite=0 next cycle).
- Address width: all addresses are N bits; no wrap-around handling is needed.

Decomposition:
- Shared package holds:
  - the state encoding (NORMAL=1'b0, FREEZE=1'b1);
  - the default parameters W, N, STARVE_MAX;
  - a write-request typedef {valid, addr[N], data[W]}.
- One sub-module: regfile_scoreboard.
  - Contains the pending vector with set/clear/priority logic and the hazard compare.
  - Instantiated once.
- Grant, counter, FSM and output register stay in the top module.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with all inputs 1 -> regWrite=0, mu_ready=0, hazard=0, pipe_freeze=0; after release, pending=0.
2. WB only: wb_valid=1, wb_addr=3, wb_data=16'hBEEF -> next cycle regWrite=1, WA=3, WD=16'hBEEF; mu_ready=1 when wb_valid=0.
3. Contention: mu_valid=1 (addr 5, data 16'h1234) and wb_valid=1 continuously, STARVE_MAX=4 -> mu_ready=0 for 4 cycles, pipe_freeze=1 in cycle 5, MU transfers that cycle; regWrite=1, WA=5 next cycle; wait_cnt returns to 0.
4. Scoreboard: mu_issue addr 2; then rd_src=2 -> hazard=1. MU returns addr 2 -> hazard stays 1 through the write cycle (in flight), then 0.
5. Simultaneous set/clear: mu_issue_addr=4 in the same cycle as an MU transfer to 4 -> pending[4]=1 afterwards; rd_dst=4 -> hazard=1.
6. Reset mid-operation: pending[1]=1 and state=FREEZE, then assert rst=0 for 1 cycle -> pending=0, pipe_freeze=0, regWrite=0, no MU transfer recorded.

Source files
------------

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default sizes,
// arbiter state encoding and the write-request record.
package regfile_wport_arbiter_pkg;

  localparam int W_DEF          = 16;
  localparam int N_DEF          = 3;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] FREEZE = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [N_DEF-1:0] addr;
    logic [W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for multi-cycle results plus the decode
// hazard compare (pending operand/destination or MU write still in flight).
module regfile_scoreboard
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  logic [N-1:0] set_addr,
  input  logic         clr_en,
  input  logic [N-1:0] clr_addr,
  input  logic         wr_mu,
  input  logic [N-1:0] wr_addr,
  input  logic [N-1:0] rd_src,
  input  logic [N-1:0] rd_dst,
  output logic         hazard
);

  localparam int R = 1 << N;

  logic [R-1:0] pending;
  logic [R-1:0] set_mask;
  logic [R-1:0] clr_mask;
  logic         wr_hit;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // NOTE: the pending vector is control state, so it is reset; data storage never is.
  always_ff @(posedge clk) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr_mask) | set_mask;  // a new issue outranks a retiring result
  end

  assign wr_hit = wr_mu & ((wr_addr == rd_src) | (wr_addr == rd_dst));
  assign hazard = rst & (pending[rd_src] | pending[rd_dst] | wr_hit);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and a multi-cycle unit, with a starvation-bounded freeze slot for the MU.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int N          = N_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_valid,
  input  logic [N-1:0] wb_addr,
  input  logic [W-1:0] wb_data,
  input  logic         mu_issue,
  input  logic [N-1:0] mu_issue_addr,
  input  logic         mu_valid,
  input  logic [N-1:0] mu_addr,
  input  logic [W-1:0] mu_data,
  output logic         mu_ready,
  input  logic [N-1:0] rd_src,
  input  logic [N-1:0] rd_dst,
  output logic         hazard,
  output logic         pipe_freeze,
  output logic         regWrite,
  output logic [N-1:0] WA,
  output logic [W-1:0] WD
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] addr;
    logic [W-1:0] data;
  } grant_t;

  logic [0:0] state;
  logic [3:0] wait_cnt;
  logic       frozen;
  logic       mu_xfer;
  logic       wr_mu;
  grant_t     grant;

  assign frozen      = (state == FREEZE);
  assign pipe_freeze = rst & frozen;
  assign mu_ready    = rst & (frozen | !wb_valid);
  assign mu_xfer     = mu_valid & mu_ready;

  // During a freeze slot the WB request is ignored; the stalled pipeline re-presents it.
  always_comb begin
    grant = '0;
    if (!frozen && wb_valid) grant = '{valid: 1'b1, addr: wb_addr, data: wb_data};
    else if (mu_xfer)        grant = '{valid: 1'b1, addr: mu_addr, data: mu_data};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else if (frozen) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else if (mu_valid && !mu_ready) begin
      wait_cnt <= wait_cnt + 4'd1;
      if (wait_cnt == STARVE_LAST) state <= FREEZE;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regWrite <= 1'b0;
      wr_mu    <= 1'b0;
      WA       <= '0;
      WD       <= '0;
    end else begin
      regWrite <= grant.valid;
      wr_mu    <= mu_xfer;
      if (grant.valid) begin
        WA <= grant.addr;
        WD <= grant.data;
      end
    end
  end

  regfile_scoreboard #(.N(N)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (mu_issue),
    .set_addr (mu_issue_addr),
    .clr_en   (mu_xfer),
    .clr_addr (mu_addr),
    .wr_mu    (regWrite & wr_mu),
    .wr_addr  (WA),
    .rd_src   (rd_src),
    .rd_dst   (rd_dst),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed, table-driven bench for regfile_wport_arbiter with a hand-written
// starvation sequence and a monitor for illegal MU issues.
module tb_regfile_wport_arbiter;
  import regfile_wport_arbiter_pkg::*;

  localparam int W = W_DEF;
  localparam int N = N_DEF;
  localparam int STARVE_MAX = STARVE_MAX_DEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid, mu_issue, mu_valid;
  logic [N-1:0] wb_addr, mu_issue_addr, mu_addr, rd_src, rd_dst;
  logic [W-1:0] wb_data, mu_data;
  logic         mu_ready, hazard, pipe_freeze, regWrite;
  logic [N-1:0] WA;
  logic [W-1:0] WD;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.W(W), .N(N), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .mu_issue(mu_issue), .mu_issue_addr(mu_issue_addr),
    .mu_valid(mu_valid), .mu_addr(mu_addr), .mu_data(mu_data), .mu_ready(mu_ready),
    .rd_src(rd_src), .rd_dst(rd_dst), .hazard(hazard), .pipe_freeze(pipe_freeze),
    .regWrite(regWrite), .WA(WA), .WD(WD)
  );

  typedef struct {
    logic         rst;
    wr_req_t      wb;
    logic         iss;
    logic [N-1:0] iss_addr;
    wr_req_t      mu;
    logic [N-1:0] rs, rd;
    logic         e_ready, e_hazard, e_freeze;
    logic         e_rw;
    logic [N-1:0] e_wa;
    logic [W-1:0] e_wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
      input logic r, input logic wv, input logic [N-1:0] wa, input logic [W-1:0] wd,
      input logic iv, input logic [N-1:0] ia,
      input logic mv, input logic [N-1:0] ma, input logic [W-1:0] md,
      input logic [N-1:0] rs, input logic [N-1:0] rd,
      input logic er, input logic eh, input logic ef,
      input logic erw, input logic [N-1:0] ewa, input logic [W-1:0] ewd);
    vec_t v;
    v.rst = r;
    v.wb = '{valid: wv, addr: wa, data: wd};
    v.iss = iv; v.iss_addr = ia;
    v.mu = '{valid: mv, addr: ma, data: md};
    v.rs = rs; v.rd = rd;
    v.e_ready = er; v.e_hazard = eh; v.e_freeze = ef;
    v.e_rw = erw; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    wb_valid = v.wb.valid; wb_addr = v.wb.addr; wb_data = v.wb.data;
    mu_issue = v.iss; mu_issue_addr = v.iss_addr;
    mu_valid = v.mu.valid; mu_addr = v.mu.addr; mu_data = v.mu.data;
    rd_src = v.rs; rd_dst = v.rd;
  endtask

  // Stimulus legality: decode must never issue to a register still pending.
  logic [(1<<N)-1:0] model_pend;
  always @(posedge clk) begin : issue_mon
    logic [(1<<N)-1:0] nx;
    if (!rst) begin
      model_pend <= '0;
    end else begin
      if (mu_issue && model_pend[mu_issue_addr]) begin
        errors++;
        checks++;
        $display("FAIL illegal_issue: addr %0d already pending at %0t", mu_issue_addr, $time);
      end
      nx = model_pend;
      if (mu_valid && mu_ready) nx[mu_addr] = 1'b0;
      if (mu_issue) nx[mu_issue_addr] = 1'b1;
      model_pend <= nx;
    end
  end

  initial begin
    int cyc;
    // rst wbv wa wd       iss ia mv ma md       rs rd  rdy hz fz  rw wa wd
    vq.push_back(mk(0, 1, 7, 16'hFFFF, 1, 7, 1, 7, 16'hFFFF, 7, 7, 0, 0, 0, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 7, 16'hFFFF, 1, 7, 1, 7, 16'hFFFF, 7, 7, 0, 0, 0, 0, 0, 16'h0000));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 7, 0, 1, 0, 0, 0, 0, 16'h0000));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 2, 1, 0, 0, 0, 0, 16'h0000));
    // WB only, then its write must not raise hazard
    vq.push_back(mk(1, 1, 3, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 3, 16'hBEEF));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 3, 0, 1, 0, 0, 0, 3, 16'hBEEF));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 6, 16'h0606, 0, 0, 1, 0, 0, 1, 6, 16'h0606));
    // Contention: four losses, freeze slot, WB re-presented
    vq.push_back(mk(1, 1, 1, 16'h1111, 0, 0, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 1, 1, 16'h1111));
    vq.push_back(mk(1, 1, 1, 16'h2222, 0, 0, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 1, 1, 16'h2222));
    vq.push_back(mk(1, 1, 1, 16'h3333, 0, 0, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 1, 1, 16'h3333));
    vq.push_back(mk(1, 1, 1, 16'h4444, 0, 0, 1, 5, 16'h1234, 0, 0, 0, 0, 0, 1, 1, 16'h4444));
    vq.push_back(mk(1, 1, 1, 16'h5555, 0, 0, 1, 5, 16'h1234, 0, 0, 1, 0, 1, 1, 5, 16'h1234));
    vq.push_back(mk(1, 1, 1, 16'h5555, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 16'h5555));
    // Counter cleared by mu_valid dropping; then freeze whose slot goes unused
    vq.push_back(mk(1, 1, 2, 16'h2001, 0, 0, 1, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2001));
    vq.push_back(mk(1, 1, 2, 16'h2002, 0, 0, 1, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2002));
    vq.push_back(mk(1, 1, 2, 16'h2003, 0, 0, 0, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2003));
    vq.push_back(mk(1, 1, 2, 16'h2004, 0, 0, 1, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2004));
    vq.push_back(mk(1, 1, 2, 16'h2005, 0, 0, 1, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2005));
    vq.push_back(mk(1, 1, 2, 16'h2006, 0, 0, 1, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2006));
    vq.push_back(mk(1, 1, 2, 16'h2007, 0, 0, 1, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2007));
    vq.push_back(mk(1, 1, 2, 16'h2008, 0, 0, 0, 5, 16'hABCD, 0, 0, 1, 0, 1, 0, 2, 16'h2007));
    vq.push_back(mk(1, 1, 2, 16'h2008, 0, 0, 0, 5, 16'hABCD, 0, 0, 0, 0, 0, 1, 2, 16'h2008));
    // Scoreboard: issue to 2, hazard through in-flight write, then clear
    vq.push_back(mk(1, 0, 0, 16'h0000, 1, 2, 0, 0, 16'h0000, 2, 0, 1, 0, 0, 0, 2, 16'h2008));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 2, 0, 1, 1, 0, 0, 2, 16'h2008));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 2, 16'h0C0C, 2, 0, 1, 1, 0, 1, 2, 16'h0C0C));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 2, 0, 1, 1, 0, 0, 2, 16'h0C0C));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 2, 0, 1, 0, 0, 0, 2, 16'h0C0C));
    // Same-cycle set and clear of 4: set wins; WB write to 4 leaves it pending
    vq.push_back(mk(1, 0, 0, 16'h0000, 1, 4, 1, 4, 16'h4444, 0, 0, 1, 0, 0, 1, 4, 16'h4444));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 4, 1, 1, 0, 0, 4, 16'h4444));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 4, 1, 1, 0, 0, 4, 16'h4444));
    vq.push_back(mk(1, 1, 4, 16'h4BBB, 0, 0, 0, 0, 16'h0000, 0, 4, 0, 1, 0, 1, 4, 16'h4BBB));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 4, 1, 1, 0, 0, 4, 16'h4BBB));
    // Reset during the freeze slot with pending[1] set
    vq.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 4, 16'h4BBB));
    vq.push_back(mk(1, 1, 3, 16'h3001, 0, 0, 1, 1, 16'h1010, 1, 0, 0, 1, 0, 1, 3, 16'h3001));
    vq.push_back(mk(1, 1, 3, 16'h3002, 0, 0, 1, 1, 16'h1010, 1, 0, 0, 1, 0, 1, 3, 16'h3002));
    vq.push_back(mk(1, 1, 3, 16'h3003, 0, 0, 1, 1, 16'h1010, 1, 0, 0, 1, 0, 1, 3, 16'h3003));
    vq.push_back(mk(1, 1, 3, 16'h3004, 0, 0, 1, 1, 16'h1010, 1, 0, 0, 1, 0, 1, 3, 16'h3004));
    vq.push_back(mk(0, 1, 3, 16'h3005, 0, 0, 1, 1, 16'h1010, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 4, 1, 0, 0, 0, 0, 16'h0000));

    foreach (vq[i]) begin
      apply(vq[i]);
      #1;
      check($sformatf("v%0d_mu_ready", i), W'(mu_ready), W'(vq[i].e_ready));
      check($sformatf("v%0d_hazard", i), W'(hazard), W'(vq[i].e_hazard));
      check($sformatf("v%0d_pipe_freeze", i), W'(pipe_freeze), W'(vq[i].e_freeze));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_regWrite", i), W'(regWrite), W'(vq[i].e_rw));
      check($sformatf("v%0d_WA", i), W'(WA), W'(vq[i].e_wa));
      check($sformatf("v%0d_WD", i), WD, vq[i].e_wd);
    end

    // Starvation bound: freeze must arrive on cycle STARVE_MAX+1 of contention.
    cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      rst = 1'b1; mu_issue = 1'b0; rd_src = '0; rd_dst = '0;
      wb_valid = 1'b1; wb_addr = 3'd6; wb_data = W'(16'h6000 + k);
      mu_valid = 1'b1; mu_addr = 3'd7; mu_data = 16'h7777;
      #1;
      if (pipe_freeze) begin
        cyc = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("starve_freeze_cycle", W'(cyc), W'(STARVE_MAX + 1));
    check("starve_mu_ready", W'(mu_ready), W'(1'b1));
    @(posedge clk);
    #1;
    check("starve_regWrite", W'(regWrite), W'(1'b1));
    check("starve_WA", W'(WA), W'(3'd7));
    check("starve_WD", WD, 16'h7777);
    mu_valid = 1'b0;
    #1;
    check("starve_after_freeze", W'(pipe_freeze), W'(1'b0));
    check("starve_after_ready", W'(mu_ready), W'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
